// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB bypass, hold-time WB snoop and load-use bubble insertion.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [63:0] id_pc,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [63:0] id_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic [7:0]  id_ctrl,
  input  logic [63:0] rf_data1,
  input  logic [63:0] rf_data2,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_stall,
  output logic        ex_valid,
  output logic [63:0] ex_pc,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [63:0] ex_rs1_data,
  output logic [63:0] ex_rs2_data,
  output logic [63:0] ex_imm,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic [7:0]  ex_ctrl,
  output logic [31:0] hazard_cnt
);
  logic        advance;
  logic        hazard;
  logic [63:0] op1;
  logic [63:0] op2;
  always_comb begin
    advance  = !ex_valid || ex_ready;
    hazard   = id_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    op1      = id_rs1 == 5'd0 ? 64'd0 : (wb_reg_write && wb_rd == id_rs1) ? wb_data : rf_data1;
    op2      = id_rs2 == 5'd0 ? 64'd0 : (wb_reg_write && wb_rd == id_rs2) ? wb_data : rf_data2;
    id_stall = id_valid && !flush && (!advance || hazard);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_ctrl      <= '0;
      hazard_cnt   <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (!advance) begin
      // a held entry must not miss a writeback to one of its sources
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1) ex_rs1_data <= wb_data;
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2) ex_rs2_data <= wb_data;
    end else if (hazard) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      hazard_cnt   <= hazard_cnt + {31'd0, ~&hazard_cnt};
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_rs1_data  <= op1;
      ex_rs2_data  <= op2;
      ex_imm       <= id_imm;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_ctrl      <= id_ctrl;
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a behavioural pipeline-register model.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [63:0] id_imm;
  logic        id_reg_write, id_mem_read;
  logic [7:0]  id_ctrl;
  logic [63:0] rf_data1, rf_data2;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        ex_ready, flush, id_stall;
  logic        ex_valid;
  logic [63:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [63:0] ex_rs1_data, ex_rs2_data, ex_imm;
  logic        ex_reg_write, ex_mem_read;
  logic [7:0]  ex_ctrl;
  logic [31:0] hazard_cnt;
  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_ctrl(id_ctrl), .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_ctrl(ex_ctrl), .hazard_cnt(hazard_cnt)
  );
  always #5 clk = ~clk;
  logic [63:0] regs [32];
  always_comb begin
    rf_data1 = regs[id_rs1];
    rf_data2 = regs[id_rs2];
  end
  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] d1, d2, imm;
    logic        rw, mr;
    logic [7:0]  ctrl;
    logic [31:0] cnt;
  } ent_t;
  ent_t m;
  logic known;
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] opnd(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    if (wb_reg_write && wb_rd == rs) return wb_data;
    return regs[rs];
  endfunction
  task automatic idle();
    reset = 0; flush = 0; ex_ready = 1; id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_imm = '0; id_reg_write = 0; id_mem_read = 0; id_ctrl = '0; wb_reg_write = 0; wb_rd = '0; wb_data = '0;
  endtask
  task automatic step();
    logic adv, hz, stall;
    #1;
    adv   = !m.v || ex_ready;
    hz    = id_valid && m.v && m.mr && m.rd != 5'd0 && (m.rd == id_rs1 || m.rd == id_rs2);
    stall = id_valid && !flush && (!adv || hz);
    if (!reset) chk("id_stall", id_stall, stall);
    if (reset) begin
      m = '{default: '0};
      known = 1;
    end else if (flush) begin
      m.v = 0; m.rw = 0; m.mr = 0; known = 0;
    end else if (!adv) begin
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs1) m.d1 = wb_data;
      if (wb_reg_write && wb_rd != 5'd0 && wb_rd == m.rs2) m.d2 = wb_data;
    end else if (hz) begin
      m.v = 0; m.rw = 0; m.mr = 0;
      if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
    end else begin
      m.v = id_valid; m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      m.d1 = opnd(id_rs1); m.d2 = opnd(id_rs2); m.imm = id_imm; m.rw = id_reg_write;
      m.mr = id_mem_read; m.ctrl = id_ctrl; known = 1;
    end
    @(posedge clk);
    if (wb_reg_write && wb_rd != 5'd0) regs[wb_rd] = wb_data;
    #1;
    chk("ex_valid", ex_valid, m.v);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("hazard_cnt", hazard_cnt, m.cnt);
    if (known) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs1", ex_rs1, m.rs1);
      chk("ex_rs2", ex_rs2, m.rs2);
      chk("ex_rd", ex_rd, m.rd);
      chk("ex_rs1_data", ex_rs1_data, m.d1);
      chk("ex_rs2_data", ex_rs2_data, m.d2);
      chk("ex_imm", ex_imm, m.imm);
      chk("ex_ctrl", ex_ctrl, m.ctrl);
    end
    @(negedge clk);
  endtask
  initial begin
    m = '{default: '0};
    known = 1;
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom} | 64'h1;
    idle();
    @(negedge clk);
    reset = 1;
    step();
    reset = 0;
    chk("reset_valid", ex_valid, 0);
    chk("reset_cnt", hazard_cnt, 0);
    regs[3] = 64'd7; regs[5] = 64'd6;
    id_valid = 1; id_rs1 = 3; id_rs2 = 5; id_rd = 1; id_pc = 64'h100; id_ctrl = 8'h21;
    #1 chk("pt_stall", id_stall, 0);
    step();
    chk("pt_valid", ex_valid, 1);
    chk("pt_rs1_data", ex_rs1_data, 64'd7);
    chk("pt_rs2_data", ex_rs2_data, 64'd6);
    regs[4] = 64'd0;
    id_rs1 = 4; wb_reg_write = 1; wb_rd = 4; wb_data = 64'h55;
    step();
    chk("byp_rs1", ex_rs1_data, 64'h55);
    id_rs1 = 0; wb_rd = 0;
    step();
    chk("byp_x0", ex_rs1_data, 64'd0);
    wb_reg_write = 0;
    id_rs1 = 1; id_rs2 = 2; id_rd = 9; id_mem_read = 1;
    step();
    id_rs2 = 9; id_rd = 10; id_mem_read = 0;
    #1 chk("lu_stall", id_stall, 1);
    step();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_cnt", hazard_cnt, 32'd1);
    step();
    chk("lu_loaded", ex_valid, 1);
    chk("lu_rd", ex_rd, 5'd10);
    id_rs1 = 12; id_rs2 = 13; id_rd = 14;
    step();
    ex_ready = 0; id_rs1 = 20; id_rd = 21; id_pc = 64'h200;
    step();
    wb_reg_write = 1; wb_rd = 12; wb_data = 64'hABCD;
    #1 chk("hs_stall", id_stall, 1);
    step();
    wb_reg_write = 0;
    step();
    chk("hs_rs1_data", ex_rs1_data, 64'hABCD);
    chk("hs_rd", ex_rd, 5'd14);
    ex_ready = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 7; id_mem_read = 1;
    step();
    id_rs1 = 7; id_mem_read = 0; ex_ready = 0; flush = 1;
    #1 chk("fl_stall", id_stall, 0);
    step();
    flush = 0;
    chk("fl_valid", ex_valid, 0);
    chk("fl_cnt", hazard_cnt, 32'd1);
    force dut.hazard_cnt = 32'hFFFF_FFFF;
    #1 release dut.hazard_cnt;
    m.cnt = 32'hFFFF_FFFF;
    ex_ready = 1; id_rs1 = 1; id_rd = 7; id_mem_read = 1;
    step();
    id_rs1 = 7; id_mem_read = 0;
    step();
    chk("sat_cnt", hazard_cnt, 32'hFFFF_FFFF);
    id_rs1 = 12; id_rd = 3; id_reg_write = 1;
    step();
    ex_ready = 0;
    step();
    reset = 1; flush = 1; wb_reg_write = 1; wb_rd = 12; wb_data = 64'h1234;
    step();
    idle();
    chk("rst_valid", ex_valid, 0);
    chk("rst_rs1_data", ex_rs1_data, 64'd0);
    chk("rst_rd", ex_rd, 5'd0);
    chk("rst_cnt", hazard_cnt, 32'd0);
    chk("rst_stall", id_stall, 0);
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(99) == 0);
      flush        = ($urandom_range(9) == 0);
      ex_ready     = ($urandom_range(9) < 6);
      id_valid     = ($urandom_range(3) != 0);
      id_pc        = {$urandom, $urandom};
      id_rs1       = 5'($urandom_range(3));
      id_rs2       = 5'($urandom_range(3));
      id_rd        = 5'($urandom_range(3));
      id_imm       = {$urandom, $urandom};
      id_reg_write = 1'($urandom_range(1));
      id_mem_read  = 1'($urandom_range(1));
      id_ctrl      = 8'($urandom);
      wb_reg_write = 1'($urandom_range(1));
      wb_rd        = 5'($urandom_range(3));
      wb_data      = {$urandom, $urandom};
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
